// File: rtl/decoder_stream_if.sv
// Handshake bundle for decoder_stream: command side (in_*) and decoded-beat side (out_*).
// master drives commands and consumes beats; slave is the decoder.
interface decoder_stream_if #(
   parameter int IN_W = 3
);
   localparam int OUT_W = 2 ** IN_W;

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_a;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_d;
   logic [IN_W-1:0]  out_a;
   logic             out_last;
   logic             out_err;

   modport master (
      output in_valid, in_a, in_mode, out_ready,
      input  in_ready, out_valid, out_d, out_a, out_last, out_err
   );

   modport slave (
      input  in_valid, in_a, in_mode, out_ready,
      output in_ready, out_valid, out_d, out_a, out_last, out_err
   );
endinterface

// File: rtl/decoder_stream.sv
// Streaming N-to-2^N decoder with one-hot, thermometer and scan modes behind a
// single registered output stage; scan walks one-hot beats up to the top line.
module decoder_stream #(
   parameter int IN_W       = 3,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input logic             clk,
   input logic             rst_n,
   decoder_stream_if.slave bus
);
   localparam int OUT_W = 2 ** IN_W;
   localparam logic [IN_W:0]    CNT_ONE = {{IN_W{1'b0}}, 1'b1};
   localparam logic [IN_W:0]    CNT_TOP = {1'b0, {IN_W{1'b1}}};
   localparam logic [OUT_W-1:0] D_ONE   = {{(OUT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [IN_W:0]    cnt_r, cnt_s;
   logic [OUT_W-1:0] dec_r, dec_s;
   logic [IN_W-1:0]  out_a_r, out_a_s;
   logic             out_valid_r, out_valid_s;
   logic             out_last_r, out_last_s;
   logic             out_err_r, out_err_s;
   logic             in_ready_s, accept_s, hs_out_s;

   function automatic logic [OUT_W-1:0] onehot(input logic [IN_W:0] idx);
      onehot = D_ONE << idx;
   endfunction

   // Bits [idx:0] set; the shift drops out for the top line so the subtraction yields all ones.
   function automatic logic [OUT_W-1:0] thermo(input logic [IN_W:0] idx);
      thermo = (onehot(idx) << 1) - D_ONE;
   endfunction

   assign hs_out_s   = out_valid_r && bus.out_ready;
   assign in_ready_s = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
   assign accept_s   = bus.in_valid && in_ready_s;

   // Next-state and output-register load selection.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      dec_s       = dec_r;
      out_a_s     = out_a_r;
      out_valid_s = out_valid_r;
      out_last_s  = out_last_r;
      out_err_s   = out_err_r;
      if (accept_s) begin
         out_valid_s = 1'b1;
         out_a_s     = bus.in_a;
         out_last_s  = 1'b1;
         out_err_s   = 1'b0;
         case (bus.in_mode)
            2'b00: dec_s = onehot({1'b0, bus.in_a});
            2'b01: dec_s = thermo({1'b0, bus.in_a});
            2'b10: begin
               dec_s = onehot({1'b0, bus.in_a});
               cnt_s = {1'b0, bus.in_a} + CNT_ONE;
               if ({1'b0, bus.in_a} == CNT_TOP) begin
                  state_s = IDLE;
               end else begin
                  out_last_s = 1'b0;
                  state_s    = SCAN;
               end
            end
            default: begin
               dec_s     = {OUT_W{1'b0}};
               out_err_s = 1'b1;
            end
         endcase
      end else if (state_r == SCAN && hs_out_s) begin
         dec_s      = onehot(cnt_r);
         out_a_s    = cnt_r[IN_W-1:0];
         out_last_s = (cnt_r == CNT_TOP);
         out_err_s  = 1'b0;
         cnt_s      = cnt_r + CNT_ONE;
         state_s    = (cnt_r == CNT_TOP) ? IDLE : SCAN;
      end else if (hs_out_s) begin
         out_valid_s = 1'b0;
      end else begin
         out_valid_s = out_valid_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= {(IN_W+1){1'b0}};
         dec_r       <= {OUT_W{1'b0}};
         out_a_r     <= {IN_W{1'b0}};
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_err_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         dec_r       <= dec_s;
         out_a_r     <= out_a_s;
         out_valid_r <= out_valid_s;
         out_last_r  <= out_last_s;
         out_err_r   <= out_err_s;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_d     = ACTIVE_LOW ? ~dec_r : dec_r;
   assign bus.out_a     = out_a_r;
   assign bus.out_last  = out_last_r;
   assign bus.out_err   = out_err_r;
endmodule
